// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN back end: data/weight widths, the
// fully-connected stage state encoding and index width helpers.
package cnn_pkg;

    localparam int DATA_W   = 18;
    localparam int WEIGHT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } fc_state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One output neuron: signed accumulator fed by unsigned data times a
// signed weight, with synchronous clear and enable.
module mac_lane
    import cnn_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic [DATA_W-1:0]          data,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int PW = DATA_W + WEIGHT_W + 1;

    logic signed [PW-1:0] prod;

    // Zero-extend the pooled value so it multiplies as a non-negative signed number.
    assign prod = $signed({1'b0, data}) * weight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
        end
    end

endmodule

// File: rtl/fc_accumulate.sv
// Fully-connected output stage: MACs the pooled stream against a stored
// weight row per input, streams the neuron scores, then reports arg-max.
module fc_accumulate
    import cnn_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 4,
    parameter int ACC_W = 32,
    localparam int IW   = idx_w(N_IN),
    localparam int OW   = idx_w(N_OUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_W-1:0]         pool_data,
    input  logic                      pool_valid,
    output logic                      in_ready,
    input  logic                      w_we,
    input  logic [IW-1:0]             w_addr,
    input  logic [N_OUT*WEIGHT_W-1:0] w_data,
    output logic [ACC_W-1:0]          out_data,
    output logic [OW-1:0]             out_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OW-1:0]             class_out,
    output logic                      done
);

    localparam logic [IW-1:0] LAST_IN  = IW'(N_IN - 1);
    localparam logic [OW-1:0] LAST_OUT = OW'(N_OUT - 1);

    fc_state_e state, next_state;

    logic [N_OUT*WEIGHT_W-1:0] weights [N_IN];
    logic [N_OUT*WEIGHT_W-1:0] row;
    logic signed [ACC_W-1:0]   acc [N_OUT];

    logic [IW-1:0]           cnt;
    logic [OW-1:0]           emit_cnt;
    logic signed [ACC_W-1:0] best_score;
    logic [OW-1:0]           best_idx;

    logic start_go;
    logic accept;
    logic emit_hs;
    logic last_in;
    logic last_out;
    logic take;

    assign start_go = (state == IDLE) && start;
    assign accept   = (state == ACCUM) && pool_valid;
    assign emit_hs  = (state == EMIT) && out_ready;
    assign last_in  = (cnt == LAST_IN);
    assign last_out = (emit_cnt == LAST_OUT);
    assign row      = weights[cnt];
    // Index 0 always seeds the running best; later lanes need strictly greater.
    assign take     = (emit_cnt == '0) || (acc[emit_cnt] > best_score);

    // Weight RAM has no reset so weights survive an aborted inference.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && w_we) begin
            weights[w_addr] <= w_data;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        mac_lane #(.ACC_W(ACC_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (start_go),
            .en     (accept),
            .data   (pool_data),
            .weight (row[j*WEIGHT_W +: WEIGHT_W]),
            .acc    (acc[j])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)              next_state = ACCUM;
            ACCUM:   if (accept && last_in)  next_state = EMIT;
            EMIT:    if (emit_hs && last_out) next_state = DONE;
            DONE:                            next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        done      = 1'b0;
        case (state)
            ACCUM: in_ready = 1'b1;
            EMIT: begin
                out_valid = 1'b1;
                out_data  = acc[emit_cnt];
                out_idx   = emit_cnt;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // class_out is loaded on the final handshake so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            emit_cnt   <= '0;
            best_score <= '0;
            best_idx   <= '0;
            class_out  <= '0;
        end else if (start_go) begin
            cnt        <= '0;
            emit_cnt   <= '0;
            best_score <= '0;
            best_idx   <= '0;
        end else begin
            if (accept) begin
                cnt <= cnt + 1'b1;
            end
            if (emit_hs) begin
                emit_cnt <= emit_cnt + 1'b1;
                if (take) begin
                    best_score <= acc[emit_cnt];
                    best_idx   <= emit_cnt;
                end
                if (last_out) begin
                    class_out <= take ? emit_cnt : best_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_accumulate.sv
// Self-checking bench for fc_accumulate: table vectors with hand-computed
// scores, handshake/reset corner sequences and randomized runs vs a model.
module tb_fc_accumulate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] pool_data;
    logic        pool_valid;
    logic        in_ready;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  class_out;
    logic        done;

    always #5 clk = ~clk;

    fc_accumulate dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pool_data  (pool_data),
        .pool_valid (pool_valid),
        .in_ready   (in_ready),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .class_out  (class_out),
        .done       (done)
    );

    typedef struct {
        int     wv[4];
        int     dbase;
        int     dstep;
        longint exp_out[4];
        int     exp_cls;
    } vec_t;

    vec_t vecs[4];
    int   mw[16][4];
    int   tests = 0;
    int   fails = 0;

    task automatic check_output(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_weights(input int wv[16][4]);
        for (int r = 0; r < 16; r++) begin
            w_we   = 1'b1;
            w_addr = 4'(r);
            for (int j = 0; j < 4; j++) begin
                w_data[j*8 +: 8] = 8'(wv[r][j]);
                mw[r][j] = wv[r][j];
            end
            @(posedge clk); #1;
        end
        w_we = 1'b0;
    endtask

    task automatic load_uniform(input int wv[4]);
        int rows[16][4];
        for (int r = 0; r < 16; r++)
            for (int j = 0; j < 4; j++)
                rows[r][j] = wv[j];
        load_weights(rows);
    endtask

    // Reference: plain dot products wrapped to 32 bits, arg-max with lowest index on ties.
    task automatic model(input int din[16], output longint e[4], output int cls);
        for (int j = 0; j < 4; j++) begin
            longint s = 0;
            for (int i = 0; i < 16; i++)
                s += longint'(din[i]) * longint'(mw[i][j]);
            e[j] = longint'(int'(s));
        end
        cls = 0;
        for (int j = 1; j < 4; j++)
            if (e[j] > e[cls]) cls = j;
    endtask

    task automatic apply_stimulus(input int din[16], input longint exp_out[4], input int exp_cls,
                                  input int gap_mode, input bit stall1, input bit rand_stall,
                                  input bit poke);
        int  accepted = 0;
        int  cyc = 0;
        int  e = 0;
        int  held = 0;
        bit  v;
        bit  rdy;
        check_output("idle_in_ready", longint'(in_ready), 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("in_ready_after_start", longint'(in_ready), 1);
        while (accepted < 16 && cyc < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            pool_valid = v;
            pool_data  = 18'(din[accepted]);
            if (poke) begin
                w_we   = 1'b1;
                w_addr = 4'($urandom_range(0, 15));
                w_data = $urandom;
                start  = 1'($urandom_range(0, 1));
            end
            check_output("in_ready_accum", longint'(in_ready), 1);
            @(posedge clk); #1;
            if (v) accepted++;
            cyc++;
        end
        pool_valid = 1'b0;
        w_we = 1'b0;
        start = 1'b0;
        if (accepted < 16) begin
            check_output("feed_timeout", accepted, 16);
            return;
        end
        cyc = 0;
        while (e < 4 && cyc < 200) begin
            if (stall1 && e == 1 && held < 3) rdy = 1'b0;
            else if (rand_stall)              rdy = $urandom_range(0, 2) != 0;
            else                              rdy = 1'b1;
            out_ready = rdy;
            if (poke) start = 1'($urandom_range(0, 1));
            check_output("out_valid", longint'(out_valid), 1);
            check_output("out_idx", longint'(out_idx), e);
            check_output($sformatf("out_data[%0d]", e), longint'($signed(out_data)), exp_out[e]);
            @(posedge clk); #1;
            if (rdy) begin
                e++;
                held = 0;
            end else begin
                held++;
            end
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        if (e < 4) begin
            check_output("emit_timeout", e, 4);
            return;
        end
        check_output("done_pulse", longint'(done), 1);
        check_output("class_out", longint'(class_out), exp_cls);
        check_output("out_valid_in_done", longint'(out_valid), 0);
        @(posedge clk); #1;
        check_output("done_one_cycle", longint'(done), 0);
        check_output("idle_after_done", longint'(in_ready), 0);
        check_output("class_out_held", longint'(class_out), exp_cls);
    endtask

    task automatic run_model(input int din[16], input int gap_mode, input bit rand_stall, input bit poke);
        longint e[4];
        int cls;
        model(din, e, cls);
        apply_stimulus(din, e, cls, gap_mode, 1'b0, rand_stall, poke);
    endtask

    initial begin
        int     din[16];
        int     ones[16];
        longint e136[4];
        int     rw[16][4];

        vecs[0].wv = '{1, 1, 1, 1};       vecs[0].dbase = 1;      vecs[0].dstep = 1;
        vecs[0].exp_out = '{136, 136, 136, 136};                     vecs[0].exp_cls = 0;
        vecs[1].wv = '{-1, 0, 1, 2};      vecs[1].dbase = 1000;   vecs[1].dstep = 0;
        vecs[1].exp_out = '{-16000, 0, 16000, 32000};                vecs[1].exp_cls = 3;
        vecs[2].wv = '{-128, -128, -128, -128}; vecs[2].dbase = 262143; vecs[2].dstep = 0;
        vecs[2].exp_out = '{-536868864, -536868864, -536868864, -536868864}; vecs[2].exp_cls = 0;
        vecs[3].wv = '{5, -3, 7, 7};      vecs[3].dbase = 100;    vecs[3].dstep = 10;
        vecs[3].exp_out = '{14000, -8400, 19600, 19600};             vecs[3].exp_cls = 2;

        rst = 1'b0; start = 1'b0; pool_data = '0; pool_valid = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", longint'(in_ready), 0);
        check_output("rst_out_valid", longint'(out_valid), 0);
        check_output("rst_out_data", longint'(out_data), 0);
        check_output("rst_out_idx", longint'(out_idx), 0);
        check_output("rst_done", longint'(done), 0);
        check_output("rst_class_out", longint'(class_out), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            load_uniform(vecs[t].wv);
            for (int i = 0; i < 16; i++) din[i] = vecs[t].dbase + i * vecs[t].dstep;
            apply_stimulus(din, vecs[t].exp_out, vecs[t].exp_cls, 0, 1'b0, 1'b0, 1'b0);
        end

        // Abort after 5 accepted inputs; weights of vector 3 must survive.
        for (int i = 0; i < 16; i++) din[i] = $urandom_range(0, 262143);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pool_valid = 1'b1;
            pool_data  = 18'(din[i]);
            @(posedge clk); #1;
        end
        pool_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_in_ready", longint'(in_ready), 0);
        check_output("mid_rst_out_valid", longint'(out_valid), 0);
        check_output("mid_rst_out_data", longint'(out_data), 0);
        check_output("mid_rst_out_idx", longint'(out_idx), 0);
        check_output("mid_rst_done", longint'(done), 0);
        check_output("mid_rst_class_out", longint'(class_out), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_model(din, 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) ones[i] = i + 1;
        e136 = '{136, 136, 136, 136};
        load_uniform(vecs[0].wv);
        apply_stimulus(ones, e136, 0, 1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(ones, e136, 0, 0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(ones, e136, 0, 0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(ones, e136, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < 16; r++)
                for (int j = 0; j < 4; j++)
                    rw[r][j] = int'($urandom_range(0, 255)) - 128;
            load_weights(rw);
            for (int i = 0; i < 16; i++) din[i] = $urandom_range(0, 262143);
            run_model(din, 2, 1'b1, n[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
